mul_iter_unit: RTL and testbench

//  Iterative radix-2 shift-add multiplier for MUL (and MLA when enabled) in the datapath.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_step.sv | 21 ++
 rtl/mul_iter_unit.sv | 130 +++++++++++++
 tb/tb_mul_iter_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier.
//   mul_state_t : sequencing states of mul_iter_unit
//   MUL_PC_IDX  : register index of the PC; writes to it are suppressed
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_t;

    localparam logic [3:0] MUL_PC_IDX = 4'hF;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add step of the iterative multiplier (purely combinational).
// Ports:
//   acc, mcand, mplier          current partial sum, shifted multiplicand, shifted multiplier
//   acc_nx, mcand_nx, mplier_nx values after this step
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_nx,
    output logic [WIDTH-1:0] mcand_nx,
    output logic [WIDTH-1:0] mplier_nx
);

    // Sum wraps modulo 2^WIDTH: only the low product bits are kept.
    assign acc_nx    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_nx  = mcand << 1;
    assign mplier_nx = mplier >> 1;

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier (MUL, optionally MLA) for the datapath.
// Takes WIDTH RUN cycles plus one DONE cycle; returns the low WIDTH bits of the
// product to the register-file write port and stalls fetch/decode via busy.
// Optional feature macro: MUL_MLA_EN (adds ra_val; accumulator starts at ra_val).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  launch request, honoured only in IDLE
//   rn_val, rm_val         multiplicand / multiplier, sampled at launch
//   ra_val                 accumulate operand (MUL_MLA_EN builds only)
//   wa_in, setflags_in     destination register and S bit, sampled at launch
//   busy                   high in RUN and DONE
//   done                   one-cycle pulse, result/wa_out valid
//   we_out, wa_out, result register-file write port
//   flag_we, flags_nz      {N,Z} update strobe and value
//
// state    | meaning
// MUL_IDLE | waiting for start
// MUL_RUN  | one shift-add step per cycle, WIDTH steps
// MUL_DONE | result presented for one cycle
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rn_val,
    input  logic [WIDTH-1:0] rm_val,
`ifdef MUL_MLA_EN
    input  logic [WIDTH-1:0] ra_val,
`endif
    input  logic [3:0]       wa_in,
    input  logic             setflags_in,
    output logic             busy,
    output logic             done,
    output logic             we_out,
    output logic [3:0]       wa_out,
    output logic [WIDTH-1:0] result,
    output logic             flag_we,
    output logic [1:0]       flags_nz
);

    mul_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] acc_nx, mcand_nx, mplier_nx;
    logic [WIDTH-1:0] acc_init;
    logic [3:0]       wa_q;
    logic             s_q;

`ifdef MUL_MLA_EN
    assign acc_init = ra_val;
`else
    assign acc_init = '0;
`endif

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .mcand     (mcand),
        .mplier    (mplier),
        .acc_nx    (acc_nx),
        .mcand_nx  (mcand_nx),
        .mplier_nx (mplier_nx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MUL_IDLE;
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            wa_q     <= '0;
            s_q      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            we_out   <= 1'b0;
            wa_out   <= '0;
            result   <= '0;
            flag_we  <= 1'b0;
            flags_nz <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= rn_val;
                        mplier <= rm_val;
                        acc    <= acc_init;
                        wa_q   <= wa_in;
                        s_q    <= setflags_in;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    acc    <= acc_nx;
                    mcand  <= mcand_nx;
                    mplier <= mplier_nx;
                    count  <= count + CNT_W'(1);
                    // Outputs are loaded from the final step directly so they
                    // are already registered when DONE is entered.
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state    <= MUL_DONE;
                        done     <= 1'b1;
                        result   <= acc_nx;
                        wa_out   <= wa_q;
                        we_out   <= (wa_q != MUL_PC_IDX);
                        flag_we  <= s_q;
                        flags_nz <= {acc_nx[WIDTH-1], (acc_nx == '0)};
                    end
                end
                MUL_DONE: begin
                    done    <= 1'b0;
                    we_out  <= 1'b0;
                    flag_we <= 1'b0;
                    busy    <= 1'b0;
                    state   <= MUL_IDLE;
                end
                default: begin
                    state <= MUL_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_unit.sv
module tb_mul_iter_unit;

    localparam int WIDTH = 32;
`ifdef MUL_MLA_EN
    localparam bit MLA = 1'b1;
`else
    localparam bit MLA = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] rn_val, rm_val, ra_val;
    logic [3:0]       wa_in;
    logic             setflags_in;
    logic             busy, done, we_out, flag_we;
    logic [3:0]       wa_out;
    logic [WIDTH-1:0] result;
    logic [1:0]       flags_nz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_iter_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rn_val      (rn_val),
        .rm_val      (rm_val),
`ifdef MUL_MLA_EN
        .ra_val      (ra_val),
`endif
        .wa_in       (wa_in),
        .setflags_in (setflags_in),
        .busy        (busy),
        .done        (done),
        .we_out      (we_out),
        .wa_out      (wa_out),
        .result      (result),
        .flag_we     (flag_we),
        .flags_nz    (flags_nz)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision product (plus accumulate), truncated to WIDTH.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, b, ra);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        if (MLA) p = p + longint'(ra);
        return p[WIDTH-1:0];
    endfunction

    // Launch one operation and check it; optionally re-pulse start while busy
    // (cycles 5 and 32 of the operation, counting the start cycle as 0).
    task automatic run_op(input logic [WIDTH-1:0] a, b, ra, input logic [3:0] wa,
                          input logic s, input bit repulse);
        logic [WIDTH-1:0] exp;
        int lat;
        int extra;
        exp = model(a, b, ra);
        @(negedge clk);
        rn_val = a; rm_val = b; ra_val = ra; wa_in = wa; setflags_in = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rn_val = $urandom; rm_val = $urandom; ra_val = $urandom;
        wa_in = 4'($urandom); setflags_in = 1'($urandom);
        check("busy_run", busy, 1);
        lat = 1;
        while (lat < 40 && !done) begin
            start = (repulse && (lat == 5 || lat == 32));
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, 33);
        check("result", result, exp);
        check("done", done, 1);
        check("busy_done", busy, 1);
        check("we_out", we_out, (wa != 4'hF));
        check("wa_out", wa_out, wa);
        check("flag_we", flag_we, s);
        check("flags_nz", flags_nz, {exp[WIDTH-1], exp == 0});
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("result_hold", result, exp);
        if (repulse) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("no_second_done", extra, 0);
            check("result_kept", result, exp);
        end
    endtask

    initial begin
        int dones;
        reset = 1'b1; start = 1'b0; rn_val = '0; rm_val = '0; ra_val = '0;
        wa_in = '0; setflags_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", we_out, 0);
        check("rst_result", result, 0);
        check("rst_wa", wa_out, 0);
        check("rst_flags", {flag_we, flags_nz}, 0);
        reset = 1'b0;

        run_op(32'd3, 32'd5, 32'd0, 4'd2, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'd4, 1'b1, 1'b0);
        run_op(32'h80000000, 32'd2, 32'd0, 4'd1, 1'b1, 1'b0);
        run_op(32'h80000000, 32'd1, 32'd0, 4'd1, 1'b1, 1'b0);
        run_op(32'd7, 32'd7, 32'd0, 4'hF, 1'b1, 1'b0);
        run_op(32'd1234, 32'd5678, 32'd0, 4'd9, 1'b0, 1'b1);
        run_op(32'd2, 32'd3, 32'd10, 4'd3, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'd1, 32'd1, 4'd5, 1'b1, 1'b0);

        // Reset during RUN aborts without any write.
        @(negedge clk);
        rn_val = 32'd9; rm_val = 32'd9; wa_in = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || we_out) dones++;
        end
        check("abort_no_write", dones, 0);
        run_op(32'd11, 32'd13, 32'd0, 4'd7, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] a, b, ra;
            a = $urandom; b = $urandom; ra = $urandom;
            if (i % 5 == 0) b = 32'($urandom_range(0, 3));
            run_op(a, b, ra, 4'($urandom_range(0, 15)), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
